// File: rtl/vt_pkg.sv
// Shared widths, object-word slice offsets, miss code and FSM state enum
// for the ray dispatcher and its nearest-hit selector.
package vt_pkg;

    localparam int ORIGIN_W = 28;
    localparam int DIR_XY_W = 11;
    localparam int DIR_Z_W  = 9;
    localparam int DIR_W    = 2 * DIR_XY_W + DIR_Z_W;
    localparam int OBJ_W    = 48;
    localparam int T_W      = 10;
    localparam int COLOR_W  = 12;

    // object word: {color, radius, x, y, z}
    localparam int OBJ_COLOR_LSB  = 36;
    localparam int OBJ_RADIUS_LSB = 28;
    localparam int OBJ_X_LSB      = 18;
    localparam int OBJ_Y_LSB      = 8;
    localparam int OBJ_Z_LSB      = 0;

    localparam logic [T_W-1:0] T_MISS = 10'h3FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_TRACE,
        ST_COMPARE,
        ST_OUTPUT
    } disp_state_e;

endpackage

// File: rtl/nearest_hit_sel.sv
// Tracks the nearest hit for the current pixel. Exposes the next-state
// colour so the pixel word can be loaded on the same edge as the last compare.
module nearest_hit_sel
    import vt_pkg::*;
#(
    parameter logic [COLOR_W-1:0] BG_COLOR = 12'h000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               cmp_en_i,
    input  logic [T_W-1:0]     t_i,
    input  logic [COLOR_W-1:0] color_i,
    output logic [COLOR_W-1:0] best_color_d_o
);

    logic [T_W-1:0]     best_t_q, best_t_d;
    logic [COLOR_W-1:0] best_color_q, best_color_d;

    // strict less-than: on a tie the earlier (lower index) object wins
    always_comb begin
        best_t_d     = best_t_q;
        best_color_d = best_color_q;
        if (clear_i) begin
            best_t_d     = T_MISS;
            best_color_d = BG_COLOR;
        end else if (cmp_en_i && (t_i != T_MISS) && (t_i < best_t_q)) begin
            best_t_d     = t_i;
            best_color_d = color_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            best_t_q     <= T_MISS;
            best_color_q <= BG_COLOR;
        end else begin
            best_t_q     <= best_t_d;
            best_color_q <= best_color_d;
        end
    end

    assign best_color_d_o = best_color_d;

endmodule

// File: rtl/ray_dispatcher.sv
// Raster-order ray producer: per pixel walks the object table through the
// sphere tracer, keeps the nearest hit and hands one shaded pixel to the writer.
module ray_dispatcher
    import vt_pkg::*;
#(
    parameter int                  H_RES     = 640,
    parameter int                  V_RES     = 480,
    parameter int                  N_OBJ     = 4,
    parameter int                  TRACE_LAT = 4,
    parameter logic [DIR_Z_W-1:0]  FOCAL     = 9'd256,
    parameter logic [COLOR_W-1:0]  BG_COLOR  = 12'h000,
    localparam int                 AW        = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ORIGIN_W-1:0] cam_pos,
    output logic [ORIGIN_W-1:0] init,
    output logic [DIR_W-1:0]    dir,
    output logic [OBJ_W-1:0]    object_in,
    input  logic [T_W-1:0]      t_in,
    output logic [AW-1:0]       obj_addr,
    input  logic [OBJ_W-1:0]    obj_data,
    output logic [9:0]          pix_x,
    output logic [8:0]          pix_y,
    output logic [COLOR_W-1:0]  pix_color,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                busy,
    output logic                frame_done
);

    localparam int LAT_W = (TRACE_LAT > 1) ? $clog2(TRACE_LAT) : 1;
    localparam logic [DIR_XY_W-1:0] HALF_H = DIR_XY_W'(H_RES / 2);
    localparam logic [DIR_XY_W-1:0] HALF_V = DIR_XY_W'(V_RES / 2);

    disp_state_e         state_q;
    logic [ORIGIN_W-1:0] init_q;
    logic [DIR_W-1:0]    dir_q;
    logic [OBJ_W-1:0]    object_q;
    logic [AW-1:0]       obj_idx_q;
    logic [LAT_W-1:0]    lat_cnt_q;
    logic [9:0]          px_q;
    logic [8:0]          py_q;
    logic [COLOR_W-1:0]  pix_color_q;
    logic                pix_valid_q;
    logic                busy_q;
    logic                frame_done_q;

    logic [DIR_XY_W-1:0] dir_x_d, dir_y_d;
    logic [COLOR_W-1:0]  best_color_d;
    logic                sel_clear;
    logic                last_obj;
    logic                last_px;
    logic                last_line;

    assign dir_x_d   = {1'b0, px_q} - HALF_H;
    assign dir_y_d   = HALF_V - {2'b00, py_q};
    assign last_obj  = (obj_idx_q == AW'(N_OBJ - 1));
    assign last_px   = (px_q == 10'(H_RES - 1));
    assign last_line = (py_q == 9'(V_RES - 1));
    assign sel_clear = ((state_q == ST_IDLE) && start) ||
                       ((state_q == ST_OUTPUT) && pix_ready);

    nearest_hit_sel #(
        .BG_COLOR(BG_COLOR)
    ) u_sel (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (sel_clear),
        .cmp_en_i       (state_q == ST_COMPARE),
        .t_i            (t_in),
        .color_i        (object_q[OBJ_COLOR_LSB +: COLOR_W]),
        .best_color_d_o (best_color_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            init_q       <= '0;
            dir_q        <= '0;
            object_q     <= '0;
            obj_idx_q    <= '0;
            lat_cnt_q    <= '0;
            px_q         <= '0;
            py_q         <= '0;
            pix_color_q  <= '0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        init_q    <= cam_pos;
                        px_q      <= '0;
                        py_q      <= '0;
                        obj_idx_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    object_q  <= obj_data;
                    dir_q     <= {dir_x_d, dir_y_d, FOCAL};
                    lat_cnt_q <= LAT_W'(TRACE_LAT - 1);
                    state_q   <= ST_TRACE;
                end
                ST_TRACE: begin
                    if (lat_cnt_q == '0) begin
                        state_q <= ST_COMPARE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (last_obj) begin
                        pix_color_q <= best_color_d;
                        pix_valid_q <= 1'b1;
                        state_q     <= ST_OUTPUT;
                    end else begin
                        obj_idx_q <= obj_idx_q + 1'b1;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_OUTPUT: begin
                    if (pix_ready) begin
                        pix_valid_q <= 1'b0;
                        obj_idx_q   <= '0;
                        if (last_px && last_line) begin
                            px_q         <= '0;
                            py_q         <= '0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            if (last_px) begin
                                px_q <= '0;
                                py_q <= py_q + 1'b1;
                            end else begin
                                px_q <= px_q + 1'b1;
                            end
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign init       = init_q;
    assign dir        = dir_q;
    assign object_in  = object_q;
    assign obj_addr   = obj_idx_q;
    assign pix_x      = px_q;
    assign pix_y      = py_q;
    assign pix_color  = pix_color_q;
    assign pix_valid  = pix_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 frame with two objects, a
// scripted two-cycle tracer stub and a combinational object ROM.
module tb_ray_dispatcher;

    localparam logic [11:0] BG = 12'h5A5;
    localparam logic [11:0] C0 = 12'hA00;
    localparam logic [11:0] C1 = 12'h0B0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [27:0] cam_pos;
    logic [27:0] init;
    logic [30:0] dir;
    logic [47:0] object_in;
    logic [9:0]  t_in;
    logic [0:0]  obj_addr;
    logic [47:0] obj_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_color;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    int busy_low = 0;

    logic [9:0]  t_tab [8][2];
    logic [9:0]  trace_pipe [2];
    logic [11:0] exp_color [8];

    ray_dispatcher #(
        .H_RES(4), .V_RES(2), .N_OBJ(2), .TRACE_LAT(2),
        .FOCAL(9'd256), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cam_pos(cam_pos),
        .init(init), .dir(dir), .object_in(object_in), .t_in(t_in),
        .obj_addr(obj_addr), .obj_data(obj_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // object index is stored in the x field so the tracer stub can recognise it
    assign obj_data = (obj_addr == 1'b0) ? {C0, 8'd10, 10'd0, 10'd0, 8'd0}
                                         : {C1, 8'd20, 10'd1, 10'd0, 8'd0};

    function automatic logic [9:0] stub_t(input logic [30:0] d, input logic [47:0] o);
        int px, py, oi;
        px = int'($signed(d[30:20])) + 2;
        py = 1 - int'($signed(d[19:9]));
        oi = int'(o[27:18]);
        if (px < 0 || px > 3 || py < 0 || py > 1 || oi > 1) return 10'h3FF;
        return t_tab[py*4 + px][oi];
    endfunction

    always @(posedge clk) begin
        trace_pipe[0] <= stub_t(dir, object_in);
        trace_pipe[1] <= trace_pipe[0];
    end
    assign t_in = trace_pipe[1];

    always @(negedge clk) if (frame_done) fd_cnt++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input bit drop_ready, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (drop_ready && cyc == 1) pix_ready = 1'b0;
            if (!busy) busy_low++;
        end while (!pix_valid && cyc < 200);
        if (!pix_valid) check_val("valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int stray;
        logic [9:0]  sx;
        logic [8:0]  sy;
        logic [11:0] sc;
        logic [0:0]  sa;

        t_tab[0] = '{10'd40,  10'd25};
        t_tab[1] = '{10'd30,  10'd30};
        t_tab[2] = '{10'd0,   10'h3FF};
        t_tab[3] = '{10'h3FF, 10'h3FF};
        t_tab[4] = '{10'h3FF, 10'd7};
        t_tab[5] = '{10'h100, 10'h3FE};
        t_tab[6] = '{10'h3FE, 10'h3FF};
        t_tab[7] = '{10'd5,   10'd0};
        exp_color = '{C1, C0, C0, BG, C1, C0, C0, C1};

        rst = 1'b0; start = 1'b0; pix_ready = 1'b1; cam_pos = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pix_valid", pix_valid, 0);
        check_val("rst_busy", busy, 0);
        rst = 1'b1;

        // reset in the middle of a trace
        cam_pos = 28'h1234567;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check_val("pre_rst_busy", busy, 1);
        check_val("pre_rst_dir", dir, {11'h7FE, 11'h001, 9'h100});
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_val("mid_rst_init", init, 0);
        check_val("mid_rst_dir", dir, 0);
        check_val("mid_rst_object_in", object_in, 0);
        check_val("mid_rst_obj_addr", obj_addr, 0);
        check_val("mid_rst_pix_x", pix_x, 0);
        check_val("mid_rst_pix_y", pix_y, 0);
        check_val("mid_rst_pix_color", pix_color, 0);
        check_val("mid_rst_pix_valid", pix_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_frame_done", frame_done, 0);
        stray = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (pix_valid || busy) stray++;
        end
        check_val("post_rst_idle", stray, 0);

        // full frame
        cam_pos = 28'hABCDE12;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cam_pos = 28'h0;
        check_val("init_capture", init, 28'hABCDE12);
        check_val("busy_rise", busy, 1);
        wait_valid(1'b0, cyc);
        check_val("first_valid_lat", cyc, 8);

        for (int p = 0; p < 8; p++) begin
            if (p > 0) begin
                wait_valid(p == 1, cyc);
                if (p == 1) check_val("pix_period", cyc, 9);
                if (p == 2) check_val("bp_release_lat", cyc, 9);
            end
            check_val($sformatf("pix%0d_x", p), pix_x, p % 4);
            check_val($sformatf("pix%0d_y", p), pix_y, p / 4);
            check_val($sformatf("pix%0d_color", p), pix_color, exp_color[p]);
            check_val($sformatf("pix%0d_init", p), init, 28'hABCDE12);
            if (p == 0) check_val("dir_0_0", dir, {11'h7FE, 11'h001, 9'h100});
            if (p == 7) check_val("dir_3_1", dir, {11'h001, 11'h000, 9'h100});
            if (p == 1) begin
                sx = pix_x; sy = pix_y; sc = pix_color; sa = obj_addr;
                repeat (5) begin
                    @(posedge clk); #1;
                    check_val("bp_valid", pix_valid, 1);
                    check_val("bp_x", pix_x, sx);
                    check_val("bp_y", pix_y, sy);
                    check_val("bp_color", pix_color, sc);
                    check_val("bp_obj_addr", obj_addr, sa);
                end
                pix_ready = 1'b1;
            end
            if (p == 3) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end

        @(posedge clk); #1;
        check_val("frame_done_pulse", frame_done, 1);
        check_val("busy_fall", busy, 0);
        check_val("valid_after_last", pix_valid, 0);
        @(posedge clk); #1;
        check_val("frame_done_end", frame_done, 0);
        stray = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (pix_valid || busy) stray++;
        end
        check_val("idle_after_frame", stray, 0);
        check_val("frame_done_count", fd_cnt, 1);
        check_val("busy_low_in_frame", busy_low, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Frame-level ray producer that drives the `ray_tracer_sphere` input side and consumes its `t_out`. For each pixel in raster order it:

- builds the ray direction,
- walks the object table one sphere at a time,
- keeps the nearest hit,
- emits one shaded pixel over a valid/ready handshake.

It sits between the frame controller (start/done) and the pixel writer (frame buffer).

## Interface
- H_RES, 640: pixels per line.
- V_RES, 480: lines per frame.
- N_OBJ, 4: object table entries (≥1).
- TRACE_LAT, 4: tracer cycles from stable inputs to valid `t_out` (≥1).
- FOCAL, 9'd256: dir z component.
- BG_COLOR, 12'h000: colour on miss.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  begin frame; sampled only in IDLE.
- cam_pos  in  28  ray origin {x[9:0], y[9:0], z[7:0]}; captured on accepted start.
- init  out  28  origin to tracer.
- dir  out  31  {x[10:0], y[10:0], z[8:0]}, two's complement x/y, unsigned z.
- object_in  out  48  {color[11:0], radius[7:0], x[9:0], y[9:0], z[7:0]}.
- t_in  in  10  tracer `t_out`; 10'h3FF = miss.
- obj_addr  out  $clog2(N_OBJ)  object ROM address; ROM is combinational.
- obj_data  in  48  object ROM word.
- pix_x  out  10  pixel column.
- pix_y  out  9  pixel row.
- pix_color  out  12  pixel colour.
- pix_valid  out  1  pixel word valid.
- pix_ready  in  1  writer accepts.
- busy  out  1  high from accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after last pixel handshake.

## Operation
- FSM states: IDLE, FETCH, TRACE, COMPARE, OUTPUT.
- IDLE
  - On `start=1`: capture cam_pos into `init`; clear px, py, obj index, best_t=10'h3FF, best_color=BG_COLOR; go to FETCH.
- FETCH (1 cycle)
  - `obj_addr` = obj index.
  - At exit, load `object_in` from `obj_data`.
  - At exit, load `dir` = {px − H_RES/2, V_RES/2 − py, FOCAL}, all sign-extended to field width.
- TRACE
  - Counter runs TRACE_LAT cycles.
  - `init`, `dir` and `object_in` are held constant.
- COMPARE (1 cycle)
  - Sample `t_in`.
  - If t_in ≠ 3FF and t_in < best_t (strict; ties keep the lower index): best_t ← t_in, best_color ← object_in[47:36].
  - t_in = 0 is a valid hit.
  - If obj index < N_OBJ−1: increment and go to FETCH. Otherwise go to OUTPUT.
- OUTPUT
  - pix_valid=1; pix_x/pix_y/pix_color = px/py/best_color, held stable until pix_ready.
  - On handshake: advance px (wrap at H_RES−1 to 0, py+1); reset obj index and best_t/best_color.
  - After the handshake for (H_RES−1, V_RES−1): pulse frame_done, go to IDLE. Otherwise go to FETCH.
- `start` while busy is ignored.
- Pixels advance only on pix_valid & pix_ready.

## Timing
- Reset (rst=0 at an edge) returns to IDLE from any state, including mid-frame. All outputs return to 0: init, dir, object_in, obj_addr, pix_x, pix_y, pix_color, pix_valid, busy, frame_done. No partial pixel is emitted afterwards.
- Per object: TRACE_LAT+2 cycles.
- Start to first pix_valid: if start is sampled at edge E0, pix_valid is high from edge E0 + N_OBJ·(TRACE_LAT+2).
- Pixel to pixel, with pix_ready held high: N_OBJ·(TRACE_LAT+2) + 1 cycles.
- busy rises at E0 and falls with the frame_done pulse.
- Back-pressure: OUTPUT stalls indefinitely. No ROM or tracer activity occurs and outputs stay stable.

## Structure
- Shared package `vt_pkg` holds:
  - field-width constants for origin, dir and object;
  - slice offsets within `object_in`;
  - `T_MISS = 10'h3FF`;
  - the FSM state enum.
- Sub-module `nearest_hit_sel` holds the best_t/best_color registers, the compare and the clear.

## Test plan
Bench uses a behavioural tracer stub with a TRACE_LAT-cycle scripted `t_out`. Parameters: H_RES=4, V_RES=2, N_OBJ=2, TRACE_LAT=2, FOCAL=256.

1. Reset: rst low one edge during TRACE → next cycle every output is 0 and state is IDLE; a later start runs normally.
2. Direction: pixel (0,0) → dir = {11'h7FE, 11'h001, 9'h100}. Pixel (3,1) → {11'h001, 11'h000, 9'h100}. init equals cam_pos captured at start.
3. Nearest hit:
   - obj0 t=40, obj1 t=25 → obj1 colour.
   - t=30/30 → obj0 colour.
   - obj0 t=0 → obj0 colour.
4. All miss (t=3FF for both) → pix_color=BG_COLOR. First pix_valid exactly 8 cycles after the start edge.
5. Back-pressure: pix_ready low 5 cycles → pix_valid and pixel fields constant, obj_addr unchanged. Release → next pixel valid 9 cycles after the handshake.
6. Full frame:
   - 8 pixels arrive in raster order; frame_done pulses once, one cycle after the (3,1) handshake.
   - start pulsed mid-frame has no effect.
   - busy is high throughout the frame.
